imm_ext_arbiter: RTL and testbench
==================================

# imm_ext_arbiter

Shared immediate-extension unit with a two-requester round-robin arbiter in front of it and a one-entry registered result stage behind it. The instruction-decode path (requester 0) and the branch/jump target path (requester 1) each present a 16-bit immediate and an extension mode. The block grants one request per cycle, computes the 32-bit sign-, zero-, upper- or branch-offset extension, and holds the result under a valid/ready handshake until the consumer takes it.

## Interface
- IN_W, 16, immediate width; fixed at 16 in this revision
- OUT_W, 32, result width; must equal 2*IN_W
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_imm  input  IN_W  requester 0 immediate
- req0_mode  input  2  requester 0 extension mode
- req1_valid, req1_ready, req1_imm, req1_mode: same as requester 0, for requester 1
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer takes the result this cycle
- rsp_data  output  OUT_W  extended result
- rsp_id  output  1  requester that produced rsp_data

## Operation
- Modes, applied to imm:
  - 00 sign extend: {{16{imm[15]}}, imm}
  - 01 zero extend: {16'b0, imm}
  - 10 upper: {imm, 16'b0}
  - 11 branch offset: {{14{imm[15]}}, imm, 2'b00}, i.e. sign extend then shift left 2
- Result stage has two states:
  - EMPTY: rsp_valid=0
  - FULL: rsp_valid=1
- can_accept = EMPTY, or (FULL and rsp_ready). The output register drains and refills in the same cycle.
- Grant (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the requester selected by priority pointer `ptr` wins.
  - Neither valid: no grant.
- reqX_ready = can_accept and grant==X. At most one ready is high per cycle. Ready never depends on the requester's own imm or mode.
- Transfer happens when reqX_valid and reqX_ready are both high. On the clock edge after a transfer:
  - rsp_data is loaded with ext(imm, mode) and rsp_id with X.
  - State becomes FULL.
  - ptr is set to the other requester (1-X).
- FULL with rsp_ready=1 and no transfer: state becomes EMPTY. rsp_data and rsp_id keep their last values.
- FULL with rsp_ready=0: rsp_data and rsp_id are held stable. Both readies are low.
- ptr changes only on a transfer. With one requester valid and the other idle, that requester is served every cycle.
- Fairness: a continuously valid requester waits at most one transfer.
- mode and imm are sampled only at the transfer edge. Values on a non-granted requester are ignored.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0 (requester 0 has priority first), state EMPTY.
- Readies are combinational from inputs and state. With no valid inputs they are 0 during reset.
- rst asserted at any time forces EMPTY immediately, without waiting for a clock edge. A held result is discarded and ptr returns to 0.
- Latency: transfer at edge N gives rsp_valid=1 with data from edge N onward.
- Throughput: one result per cycle while rsp_ready=1 and any requester is valid.
- Once asserted, rsp_valid stays high until a cycle with rsp_ready=1. No result is ever dropped or overwritten while unacknowledged.

## Test plan
- **Single sign extend.** After reset, req0 asserts imm=0xFFE3 (-29), mode 00, rsp_ready=1.
  - Required: req0_ready=1 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_data=0xFFFFFFE3, rsp_id=0.
  - With 0x002D (45): result 0x0000002D.
- **All modes, imm=0x8001, one per cycle on req1.**
  - Mode 00 → 0xFFFF8001.
  - Mode 01 → 0x00008001.
  - Mode 10 → 0x80010000.
  - Mode 11 → 0xFFFE0004.
  - rsp_id=1 for every result.
- **Contention.** Both requesters valid for 6 cycles, rsp_ready=1.
  - Required: rsp_id sequence 0,1,0,1,0,1 and exactly one ready per cycle.
- **Backpressure.** A result is held with rsp_ready=0 for 3 cycles while both requesters are valid.
  - Required: rsp_data and rsp_id stable and both readies 0.
  - The cycle rsp_ready rises, the ptr-selected requester is accepted and its result appears the next cycle.
- **Async reset mid-hold.** Pulse rst between clock edges while FULL.
  - Required: rsp_valid=0 before the next edge and rsp_data=0.
  - First grant after reset goes to req0 when both are valid.
- **Single-requester streaming.** Only req1 valid for 4 cycles, rsp_ready=1.
  - Required: 4 back-to-back results, req1_ready=1 every cycle, and ptr does not block req1.

Source files
------------

// File: rtl/imm_ext_if.sv
// Requester/consumer bundle for the shared immediate-extension unit.
// The slave side is the extension unit; the master side is the requesters plus the consumer.
interface imm_ext_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [IN_W-1:0] req0_imm;
  logic [1:0]      req0_mode;

  logic            req1_valid;
  logic            req1_ready;
  logic [IN_W-1:0] req1_imm;
  logic [1:0]      req1_mode;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_imm, req0_mode,
    output req1_valid, req1_imm, req1_mode,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_imm, req0_mode,
    input  req1_valid, req1_imm, req1_mode,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding a shared immediate extender,
// with a one-entry registered result stage under a valid/ready handshake.
module imm_ext_arbiter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input logic      clk,
  input logic      rst,
  imm_ext_if.slave bus
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [1:0] M_SIGN   = 2'b00;
  localparam logic [1:0] M_ZERO   = 2'b01;
  localparam logic [1:0] M_UPPER  = 2'b10;
  localparam logic [1:0] M_BRANCH = 2'b11;

  logic [0:0]       r_state;
  logic             r_ptr;
  logic [OUT_W-1:0] r_data;
  logic             r_id;

  logic             w_can_accept;
  logic             w_any_valid;
  logic             w_grant_id;
  logic             w_xfer;
  logic [IN_W-1:0]  w_imm;
  logic [1:0]       w_mode;
  logic [OUT_W-1:0] w_ext;

  // The output register may drain and refill on the same edge.
  always_comb begin
    w_can_accept = (r_state == S_EMPTY) || bus.rsp_ready;
    w_any_valid  = bus.req0_valid || bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      w_grant_id = r_ptr;
    else
      w_grant_id = bus.req1_valid;
    w_xfer = w_can_accept && w_any_valid;
  end

  assign bus.req0_ready = w_xfer && !w_grant_id;
  assign bus.req1_ready = w_xfer &&  w_grant_id;

  always_comb begin
    w_imm  = w_grant_id ? bus.req1_imm  : bus.req0_imm;
    w_mode = w_grant_id ? bus.req1_mode : bus.req0_mode;
    w_ext  = '0;
    unique case (w_mode)
      M_SIGN:   w_ext = {{(OUT_W-IN_W){w_imm[IN_W-1]}}, w_imm};
      M_ZERO:   w_ext = {{(OUT_W-IN_W){1'b0}}, w_imm};
      M_UPPER:  w_ext = {w_imm, {(OUT_W-IN_W){1'b0}}};
      M_BRANCH: w_ext = {{(OUT_W-IN_W-2){w_imm[IN_W-1]}}, w_imm, 2'b00};
      default:  w_ext = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_ptr   <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
    end else if (w_xfer) begin
      r_state <= S_FULL;
      r_data  <= w_ext;
      r_id    <= w_grant_id;
      r_ptr   <= ~w_grant_id;
    end else if (bus.rsp_ready) begin
      r_state <= S_EMPTY;
    end
  end

  assign bus.rsp_valid = (r_state == S_FULL);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_id    = r_id;

  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(bus.req0_ready && bus.req1_ready));
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: directed vector table, hand sequences for async
// reset, and a randomized run against a queue-based reference model.
module tb_imm_ext_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  imm_ext_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_ext_arbiter #(.IN_W(16), .OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v0;
    logic [15:0] i0;
    logic [1:0]  m0;
    logic        v1;
    logic [15:0] i1;
    logic [1:0]  m1;
    logic        rr;
    logic        e_r0;
    logic        e_r1;
    logic        e_v;
    logic [31:0] e_d;
    logic        e_id;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic v0, logic [15:0] i0, logic [1:0] m0,
                              logic v1, logic [15:0] i1, logic [1:0] m1,
                              logic rr, logic e_r0, logic e_r1,
                              logic e_v, logic [31:0] e_d, logic e_id);
    vec_t r;
    r.v0 = v0; r.i0 = i0; r.m0 = m0;
    r.v1 = v1; r.i1 = i1; r.m1 = m1;
    r.rr = rr; r.e_r0 = e_r0; r.e_r1 = e_r1;
    r.e_v = e_v; r.e_d = e_d; r.e_id = e_id;
    return r;
  endfunction

  // Reference extension computed with integer arithmetic.
  function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [1:0] mode);
    int s;
    s = int'($signed(imm));
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic v0, logic [15:0] i0, logic [1:0] m0,
                       logic v1, logic [15:0] i1, logic [1:0] m1, logic rr);
    bus.req0_valid = v0; bus.req0_imm = i0; bus.req0_mode = m0;
    bus.req1_valid = v1; bus.req1_imm = i1; bus.req1_mode = m1;
    bus.rsp_ready  = rr;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Random-phase model state.
  logic [31:0] q_data[$];
  logic        q_id[$];
  logic [31:0] shown_d;
  logic        shown_id;
  int          last_served;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b0);
    #1;
    chk("reset_r0",    32'(bus.req0_ready), 32'd0);
    chk("reset_r1",    32'(bus.req1_ready), 32'd0);
    chk("reset_valid", 32'(bus.rsp_valid),  32'd0);
    chk("reset_data",  bus.rsp_data,        32'd0);
    chk("reset_id",    32'(bus.rsp_id),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // v0 i0 m0 | v1 i1 m1 | rr | r0 r1 | next valid data id
    vt.push_back(mk(1, 16'hFFE3, 0, 0, 16'h0,    0, 1, 1, 0, 1, 32'hFFFFFFE3, 0));
    vt.push_back(mk(1, 16'h002D, 0, 0, 16'h0,    0, 1, 1, 0, 1, 32'h0000002D, 0));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h8001, 0, 1, 0, 1, 1, 32'hFFFF8001, 1));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h8001, 1, 1, 0, 1, 1, 32'h00008001, 1));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h8001, 2, 1, 0, 1, 1, 32'h80010000, 1));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h8001, 3, 1, 0, 1, 1, 32'hFFFE0004, 1));
    for (int unsigned k = 0; k < 3; k++) begin
      vt.push_back(mk(1, 16'h1111, 1, 1, 16'h2222, 1, 1, 1, 0, 1, 32'h00001111, 0));
      vt.push_back(mk(1, 16'h1111, 1, 1, 16'h2222, 1, 1, 0, 1, 1, 32'h00002222, 1));
    end
    vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 0, 0, 32'h00002222, 1));
    vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0, 0, 32'h00002222, 1));
    vt.push_back(mk(1, 16'h0005, 0, 1, 16'hFFFF, 1, 0, 1, 0, 1, 32'h00000005, 0));
    for (int unsigned k = 0; k < 3; k++)
      vt.push_back(mk(1, 16'h0005, 0, 1, 16'hFFFF, 1, 0, 0, 0, 1, 32'h00000005, 0));
    vt.push_back(mk(1, 16'h0005, 0, 1, 16'hFFFF, 1, 1, 0, 1, 1, 32'h0000FFFF, 1));
    vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 0, 0, 32'h0000FFFF, 1));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h0010, 3, 1, 0, 1, 1, 32'h00000040, 1));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h0020, 3, 1, 0, 1, 1, 32'h00000080, 1));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h0030, 3, 1, 0, 1, 1, 32'h000000C0, 1));
    vt.push_back(mk(0, 16'h0,    0, 1, 16'h0040, 3, 1, 0, 1, 1, 32'h00000100, 1));
    vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 0, 0, 32'h00000100, 1));

    foreach (vt[k]) begin
      drive(vt[k].v0, vt[k].i0, vt[k].m0, vt[k].v1, vt[k].i1, vt[k].m1, vt[k].rr);
      @(negedge clk);
      chk($sformatf("vec%0d_r0", k), 32'(bus.req0_ready), 32'(vt[k].e_r0));
      chk($sformatf("vec%0d_r1", k), 32'(bus.req1_ready), 32'(vt[k].e_r1));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", k), 32'(bus.rsp_valid), 32'(vt[k].e_v));
      chk($sformatf("vec%0d_data", k),  bus.rsp_data,       vt[k].e_d);
      chk($sformatf("vec%0d_id", k),    32'(bus.rsp_id),    32'(vt[k].e_id));
    end

    // Async reset while holding a result with ptr pointing at req1.
    drive(1, 16'h1234, 1, 0, 16'h0, 0, 0);
    @(posedge clk);
    #1;
    chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
    drive(0, 16'h0, 0, 0, 16'h0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_data",  bus.rsp_data,       32'd0);
    chk("arst_id",    32'(bus.rsp_id),    32'd0);
    #1;
    rst = 1'b0;
    drive(1, 16'h00AA, 1, 1, 16'h00BB, 1, 1);
    @(negedge clk);
    chk("post_rst_r0", 32'(bus.req0_ready), 32'd1);
    chk("post_rst_r1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_id",   32'(bus.rsp_id), 32'd0);
    chk("post_rst_data", bus.rsp_data,    32'h000000AA);

    // Randomized run against the queue model.
    do_reset();
    q_data.delete();
    q_id.delete();
    shown_d     = '0;
    shown_id    = 1'b0;
    last_served = 1;
    for (int unsigned c = 0; c < 500; c++) begin
      logic        v0, v1, rr, can, e_r0, e_r1;
      logic [15:0] i0, i1;
      logic [1:0]  m0, m1;
      int          win;
      v0 = ($urandom % 10) < 6;
      v1 = ($urandom % 10) < 6;
      rr = ($urandom % 10) < 6;
      i0 = 16'($urandom_range(0, 65535));
      i1 = 16'($urandom_range(0, 65535));
      m0 = 2'($urandom_range(0, 3));
      m1 = 2'($urandom_range(0, 3));
      drive(v0, i0, m0, v1, i1, m1, rr);

      can = (q_data.size() == 0) || rr;
      if (v0 && v1)  win = (last_served == 0) ? 1 : 0;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
      else           win = -1;
      e_r0 = can && (win == 0);
      e_r1 = can && (win == 1);

      @(negedge clk);
      chk("rnd_r0",    32'(bus.req0_ready), 32'(e_r0));
      chk("rnd_r1",    32'(bus.req1_ready), 32'(e_r1));
      chk("rnd_valid", 32'(bus.rsp_valid),  32'(q_data.size() != 0));
      chk("rnd_data",  bus.rsp_data,        shown_d);
      chk("rnd_id",    32'(bus.rsp_id),     32'(shown_id));

      if (rr && q_data.size() != 0) begin
        void'(q_data.pop_front());
        void'(q_id.pop_front());
      end
      if (can && win >= 0) begin
        shown_d  = (win == 0) ? ref_ext(i0, m0) : ref_ext(i1, m1);
        shown_id = (win == 1);
        q_data.push_back(shown_d);
        q_id.push_back(shown_id);
        last_served = win;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
